// File: rtl/du_cmd_dispatcher_if.sv
// Signal bundle between the debug-unit command dispatcher and its UART FIFOs, loader and CPU controls.
// The master modport is the dispatcher's view; slave is the surrounding system's view.
interface du_cmd_dispatcher_if #(
  parameter int NB_UART_DATA = 8
);
  logic                    i_rx_empty;
  logic [NB_UART_DATA-1:0] i_rx_data;
  logic                    o_rx_rd;
  logic                    i_tx_full;
  logic                    o_tx_wr;
  logic [NB_UART_DATA-1:0] o_tx_data;
  logic                    o_tx_start;
  logic                    o_ldr_start;
  logic                    o_ldr_rx_done;
  logic                    o_ldr_rst;
  logic                    i_ldr_rd;
  logic                    i_ldr_wr;
  logic [NB_UART_DATA-1:0] i_ldr_wdata;
  logic                    i_ldr_tx_start;
  logic                    i_ldr_done;
  logic                    i_cpu_end;
  logic                    o_cpu_halt;
  logic                    o_cpu_step;

  modport master (
    input  i_rx_empty, i_rx_data, i_tx_full, i_ldr_rd, i_ldr_wr, i_ldr_wdata,
           i_ldr_tx_start, i_ldr_done, i_cpu_end,
    output o_rx_rd, o_tx_wr, o_tx_data, o_tx_start, o_ldr_start, o_ldr_rx_done,
           o_ldr_rst, o_cpu_halt, o_cpu_step
  );

  modport slave (
    output i_rx_empty, i_rx_data, i_tx_full, i_ldr_rd, i_ldr_wr, i_ldr_wdata,
           i_ldr_tx_start, i_ldr_done, i_cpu_end,
    input  o_rx_rd, o_tx_wr, o_tx_data, o_tx_start, o_ldr_start, o_ldr_rx_done,
           o_ldr_rst, o_cpu_halt, o_cpu_step
  );
endinterface

// File: rtl/du_cmd_dispatcher.sv
// Debug-unit command dispatcher: decodes UART command bytes, hands the byte stream to the
// instruction loader during load sessions, drives CPU halt/step and answers with ACK/NAK.
module du_cmd_dispatcher #(
  parameter int NB_UART_DATA   = 8,
  parameter int NB_TIMEOUT     = 32,
  parameter int TIMEOUT_CYCLES = 400_000_000
) (
  input  logic                clk,
  input  logic                i_rst_n,
  du_cmd_dispatcher_if.master bus
);

  localparam logic [NB_UART_DATA-1:0] CMD_LOAD = NB_UART_DATA'(8'h4C);
  localparam logic [NB_UART_DATA-1:0] CMD_RUN  = NB_UART_DATA'(8'h52);
  localparam logic [NB_UART_DATA-1:0] CMD_STEP = NB_UART_DATA'(8'h53);
  localparam logic [NB_UART_DATA-1:0] CMD_HALT = NB_UART_DATA'(8'h48);
  localparam logic [NB_UART_DATA-1:0] CMD_PING = NB_UART_DATA'(8'h50);
  localparam logic [NB_UART_DATA-1:0] BYTE_ACK = NB_UART_DATA'(8'h05);
  localparam logic [NB_UART_DATA-1:0] BYTE_NAK = NB_UART_DATA'(8'h15);
  localparam logic [NB_TIMEOUT-1:0]   TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    LOAD,
    RUN,
    REPLY
  } state_t;

  state_t                  state_q, state_d;
  logic [NB_UART_DATA-1:0] cmd_q, cmd_d;
  logic [NB_UART_DATA-1:0] reply_q, reply_d;
  logic [NB_TIMEOUT-1:0]   timeout_q, timeout_d;
  logic                    halt_q, halt_d;

  logic                    rx_rd;
  logic                    tx_wr;
  logic [NB_UART_DATA-1:0] tx_data;
  logic                    tx_start;
  logic                    ldr_start;
  logic                    ldr_rx_done;
  logic                    ldr_rst;
  logic                    cpu_step;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      reply_q   <= '0;
      timeout_q <= '0;
      halt_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      reply_q   <= reply_d;
      timeout_q <= timeout_d;
      halt_q    <= halt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    reply_d     = reply_q;
    timeout_d   = timeout_q;
    halt_d      = halt_q;
    rx_rd       = 1'b0;
    tx_wr       = 1'b0;
    tx_data     = '0;
    tx_start    = 1'b0;
    ldr_start   = 1'b0;
    ldr_rx_done = 1'b0;
    ldr_rst     = 1'b0;
    cpu_step    = 1'b0;

    case (state_q)
      IDLE: begin
        // Holding the pop off during reset keeps every output quiet while reset is asserted.
        if (i_rst_n && !bus.i_rx_empty) begin
          rx_rd   = 1'b1;
          cmd_d   = bus.i_rx_data;
          state_d = DECODE;
        end
      end

      DECODE: begin
        case (cmd_q)
          CMD_LOAD: begin
            ldr_start = 1'b1;
            timeout_d = '0;
            state_d   = LOAD;
          end
          CMD_RUN: begin
            halt_d  = 1'b0;
            state_d = RUN;
          end
          CMD_STEP: begin
            cpu_step = 1'b1;
            reply_d  = BYTE_ACK;
            state_d  = REPLY;
          end
          CMD_HALT: begin
            halt_d  = 1'b1;
            reply_d = BYTE_ACK;
            state_d = REPLY;
          end
          CMD_PING: begin
            reply_d = BYTE_ACK;
            state_d = REPLY;
          end
          default: begin
            reply_d = BYTE_NAK;
            state_d = REPLY;
          end
        endcase
      end

      LOAD: begin
        ldr_rx_done = !bus.i_rx_empty;
        rx_rd       = bus.i_ldr_rd && !bus.i_rx_empty;
        tx_wr       = bus.i_ldr_wr;
        tx_data     = bus.i_ldr_wdata;
        tx_start    = bus.i_ldr_tx_start;
        timeout_d   = rx_rd ? '0 : timeout_q + NB_TIMEOUT'(1);
        // A finished loader has already acknowledged, so it beats a coincident timeout.
        if (bus.i_ldr_done) begin
          state_d = IDLE;
        end else if (timeout_q == TIMEOUT_LAST) begin
          ldr_rst = 1'b1;
          reply_d = BYTE_NAK;
          state_d = REPLY;
        end
      end

      RUN: begin
        rx_rd = !bus.i_rx_empty;
        // Non-halt bytes are dropped; a popped 'H' together with i_cpu_end still gives one ACK.
        if ((!bus.i_rx_empty && bus.i_rx_data == CMD_HALT) || bus.i_cpu_end) begin
          halt_d  = 1'b1;
          reply_d = BYTE_ACK;
          state_d = REPLY;
        end
      end

      REPLY: begin
        if (!bus.i_tx_full) begin
          tx_wr    = 1'b1;
          tx_start = 1'b1;
          tx_data  = reply_q;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.o_rx_rd       = rx_rd;
  assign bus.o_tx_wr       = tx_wr;
  assign bus.o_tx_data     = tx_data;
  assign bus.o_tx_start    = tx_start;
  assign bus.o_ldr_start   = ldr_start;
  assign bus.o_ldr_rx_done = ldr_rx_done;
  assign bus.o_ldr_rst     = ldr_rst;
  assign bus.o_cpu_halt    = halt_q;
  assign bus.o_cpu_step    = cpu_step;

endmodule

// File: tb/tb_du_cmd_dispatcher.sv
// Bench for du_cmd_dispatcher: FIFO and loader models around the DUT, with expected replies,
// halt state and pulse counts derived per command from the command-level rules.
module tb_du_cmd_dispatcher;

  localparam int NB = 8;
  localparam int TO = 16;
  localparam logic [7:0] ACK = 8'h05;
  localparam logic [7:0] NAK = 8'h15;

  logic clk = 1'b0;
  logic i_rst_n;
  always #5 clk = ~clk;

  du_cmd_dispatcher_if #(.NB_UART_DATA(NB)) bus ();

  du_cmd_dispatcher #(
    .NB_UART_DATA  (NB),
    .NB_TIMEOUT    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk    (clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  logic [7:0] ldr_sent[$];
  logic [7:0] exp_tx[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  step_cnt = 0;
  int  ldr_start_cnt = 0;
  int  ldr_rst_cnt = 0;
  int  ldr_pops = 0;
  int  ldr_target = 0;
  int  last_pop_cyc = 0;
  int  last_tx_cyc = 0;
  int  ldr_rst_cyc = 0;
  bit  ldr_active = 1'b0;
  bit  was_active;
  int  exp_step = 0;
  bit  exp_halt = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: sample outputs mid-cycle, model the FIFOs and check loader pass-through.
  always @(negedge clk) begin
    cyc++;
    was_active = ldr_active;
    if (!i_rst_n) ldr_active = 1'b0;
    if (was_active) begin
      checkOutput("load_rd_mirror", bus.o_rx_rd, bus.i_ldr_rd && !bus.i_rx_empty);
      checkOutput("load_rx_done", bus.o_ldr_rx_done, !bus.i_rx_empty);
      checkOutput("load_tx_mirror", {bus.o_tx_wr, bus.o_tx_start, bus.o_tx_data},
                  {bus.i_ldr_wr, bus.i_ldr_tx_start, bus.i_ldr_wdata});
      if (bus.i_ldr_wr) ldr_sent.push_back(bus.i_ldr_wdata);
    end
    if (bus.o_rx_rd) begin
      if (rx_q.size() != 0) void'(rx_q.pop_front());
      else checkOutput("rx_underflow", 1, 0);
      last_pop_cyc = cyc;
      if (was_active) ldr_pops++;
    end
    if (bus.o_tx_wr) begin
      tx_log.push_back(bus.o_tx_data);
      last_tx_cyc = cyc;
    end
    if (bus.o_ldr_start) begin
      ldr_start_cnt++;
      ldr_active = 1'b1;
      ldr_pops   = 0;
    end
    if (bus.o_ldr_rst) begin
      ldr_rst_cnt++;
      ldr_rst_cyc = cyc;
      ldr_active  = 1'b0;
    end
    if (bus.o_cpu_step) step_cnt++;
  end

  // Driver: FIFO head and loader requests change shortly after each rising edge.
  always @(posedge clk) begin
    #3;
    bus.i_ldr_done     = 1'b0;
    bus.i_ldr_rd       = 1'b0;
    bus.i_ldr_wr       = 1'b0;
    bus.i_ldr_tx_start = 1'b0;
    bus.i_ldr_wdata    = 8'h00;
    if (ldr_active) begin
      if (ldr_pops >= ldr_target) begin
        bus.i_ldr_done = 1'b1;
        ldr_active     = 1'b0;
      end else begin
        bus.i_ldr_rd       = ($urandom_range(0, 3) != 0);
        bus.i_ldr_wr       = ($urandom_range(0, 4) == 0);
        bus.i_ldr_tx_start = bus.i_ldr_wr;
        bus.i_ldr_wdata    = 8'($urandom);
      end
    end
    bus.i_rx_empty = (rx_q.size() == 0);
    if (rx_q.size() != 0) bus.i_rx_data = rx_q[0];
    else bus.i_rx_data = 8'h00;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic wait_drain(input string tag);
    int b = 0;
    while (rx_q.size() != 0 && b < 500) begin
      tick(1);
      b++;
    end
    checkOutput({tag, "_drain"}, rx_q.size(), 0);
  endtask

  task automatic settle_and_compare(input string tag);
    wait_drain(tag);
    tick(8);
    checkOutput({tag, "_ntx"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++)
      if (i < tx_log.size()) checkOutput($sformatf("%s_tx%0d", tag, i), tx_log[i], exp_tx[i]);
    checkOutput({tag, "_halt"}, bus.o_cpu_halt, exp_halt);
    checkOutput({tag, "_steps"}, step_cnt, exp_step);
    tx_log.delete();
    exp_tx.delete();
  endtask

  task automatic check_reset_outputs(input string pfx);
    checkOutput({pfx, "_halt"}, bus.o_cpu_halt, 1);
    checkOutput({pfx, "_rx_rd"}, bus.o_rx_rd, 0);
    checkOutput({pfx, "_tx_wr"}, bus.o_tx_wr, 0);
    checkOutput({pfx, "_tx_data"}, bus.o_tx_data, 0);
    checkOutput({pfx, "_tx_start"}, bus.o_tx_start, 0);
    checkOutput({pfx, "_ldr_start"}, bus.o_ldr_start, 0);
    checkOutput({pfx, "_ldr_rx_done"}, bus.o_ldr_rx_done, 0);
    checkOutput({pfx, "_ldr_rst"}, bus.o_ldr_rst, 0);
    checkOutput({pfx, "_cpu_step"}, bus.o_cpu_step, 0);
  endtask

  task automatic release_backpressure(input string tag);
    wait_drain(tag);
    tick($urandom_range(3, 6));
    checkOutput({tag, "_bp_hold"}, tx_log.size(), 0);
    bus.i_tx_full = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         b;
    int         pop_cyc;
    int         cnt0;
    int         kind;
    int         njunk;
    int         mode;
    bit         bp;
    logic [7:0] cmd;

    $display("[TB] starting du_cmd_dispatcher bench");
    i_rst_n       = 1'b0;
    bus.i_tx_full = 1'b0;
    bus.i_cpu_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    i_rst_n = 1'b1;
    tick(2);

    // Ping: ACK two cycles after the pop.
    applyStimulus(8'h50);
    exp_tx.push_back(ACK);
    wait_drain("ping");
    pop_cyc = last_pop_cyc;
    tick(4);
    checkOutput("ping_latency", last_tx_cyc - pop_cyc, 2);
    settle_and_compare("ping");

    applyStimulus(8'h7A);
    exp_tx.push_back(NAK);
    settle_and_compare("unknown");

    // Full load session: 132-byte frame plus EOT.
    ldr_sent.delete();
    ldr_target = 133;
    cnt0 = ldr_start_cnt;
    applyStimulus(8'h4C);
    for (int i = 0; i < 133; i++) begin
      applyStimulus((i == 132) ? 8'h04 : 8'($urandom));
      tick($urandom_range(1, 2));
    end
    b = 0;
    while (ldr_active && b < 1000) begin
      tick(1);
      b++;
    end
    checkOutput("load_done", ldr_active, 0);
    checkOutput("load_pops", ldr_pops, 133);
    checkOutput("load_start_pulses", ldr_start_cnt - cnt0, 1);
    checkOutput("load_no_rst", ldr_rst_cnt, 0);
    exp_tx = ldr_sent;
    settle_and_compare("load");

    // Load abandoned after three bytes.
    ldr_sent.delete();
    ldr_target = 1000;
    cnt0 = ldr_rst_cnt;
    applyStimulus(8'h4C);
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom));
    b = 0;
    while (ldr_rst_cnt == cnt0 && b < 200) begin
      tick(1);
      b++;
    end
    checkOutput("timeout_seen", ldr_rst_cnt - cnt0, 1);
    checkOutput("timeout_distance", ldr_rst_cyc - last_pop_cyc, TO);
    checkOutput("timeout_pops", ldr_pops, 3);
    exp_tx = ldr_sent;
    exp_tx.push_back(NAK);
    settle_and_compare("timeout");

    // Run, junk byte, then 'H' coinciding with end of program.
    applyStimulus(8'h52);
    wait_drain("run");
    tick(3);
    checkOutput("run_halt_low", bus.o_cpu_halt, 0);
    applyStimulus(8'h41);
    wait_drain("run_junk");
    tick(3);
    checkOutput("run_junk_no_reply", tx_log.size(), 0);
    checkOutput("run_junk_halt_low", bus.o_cpu_halt, 0);
    applyStimulus(8'h48);
    bus.i_cpu_end = 1'b1;
    tick(1);
    bus.i_cpu_end = 1'b0;
    exp_tx.push_back(ACK);
    settle_and_compare("run_halt_end");

    // Step under Tx backpressure.
    bus.i_tx_full = 1'b1;
    cnt0 = step_cnt;
    applyStimulus(8'h53);
    wait_drain("step_bp");
    tick(6);
    checkOutput("step_bp_pulse", step_cnt - cnt0, 1);
    checkOutput("step_bp_no_push", tx_log.size(), 0);
    bus.i_tx_full = 1'b0;
    exp_step++;
    exp_tx.push_back(ACK);
    settle_and_compare("step_bp");

    // Reset while a reply is held back: no reply afterwards.
    bus.i_tx_full = 1'b1;
    applyStimulus(8'h53);
    wait_drain("rst_reply");
    tick(4);
    exp_step++;
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_reply");
    tick(2);
    i_rst_n = 1'b1;
    bus.i_tx_full = 1'b0;
    settle_and_compare("rst_reply_after");

    // Reset in the middle of a run.
    cnt0 = ldr_rst_cnt;
    applyStimulus(8'h52);
    wait_drain("rst_run");
    tick(3);
    checkOutput("rst_run_halt_low", bus.o_cpu_halt, 0);
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_run");
    tick(2);
    i_rst_n = 1'b1;
    settle_and_compare("rst_run_after");
    checkOutput("rst_run_no_ldr_rst", ldr_rst_cnt - cnt0, 0);

    // Randomized command mix with occasional backpressure.
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 4);
      bp   = ($urandom_range(0, 2) == 0);
      if (kind == 4) begin
        applyStimulus(8'h52);
        njunk = $urandom_range(0, 3);
        for (int j = 0; j < njunk; j++) begin
          do cmd = 8'($urandom); while (cmd == 8'h48);
          applyStimulus(cmd);
          tick($urandom_range(1, 2));
        end
        wait_drain("rand_run");
        tick(2);
        checkOutput($sformatf("rand%0d_run_halt_low", it), bus.o_cpu_halt, 0);
        checkOutput($sformatf("rand%0d_run_silent", it), tx_log.size(), 0);
        if (bp) bus.i_tx_full = 1'b1;
        mode = $urandom_range(0, 2);
        if (mode != 1) applyStimulus(8'h48);
        if (mode != 0) bus.i_cpu_end = 1'b1;
        tick(1);
        bus.i_cpu_end = 1'b0;
        exp_tx.push_back(ACK);
      end else begin
        case (kind)
          0: cmd = 8'h50;
          1: cmd = 8'h53;
          2: cmd = 8'h48;
          default: do cmd = 8'($urandom); while (cmd inside {8'h4C, 8'h52, 8'h53, 8'h48, 8'h50});
        endcase
        if (bp) bus.i_tx_full = 1'b1;
        applyStimulus(cmd);
        if (kind == 1) exp_step++;
        exp_tx.push_back((kind == 3) ? NAK : ACK);
      end
      if (bp) release_backpressure($sformatf("rand%0d", it));
      settle_and_compare($sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/du_cmd_dispatcher.md
Name: du_cmd_dispatcher

Overview:
- Debug-unit front end that sits directly upstream of the instruction-memory loader.
- Pulls command bytes from the UART Rx FIFO, decodes them, and either hands the UART byte stream to the loader or drives the CPU halt/step controls.
- Returns ACK/NAK replies through the UART Tx FIFO.
- Owns a per-session timeout watchdog that recovers the loader from silent aborts.

Parameters:
NB_UART_DATA, 8, UART byte width
NB_TIMEOUT, 32, timeout counter width
TIMEOUT_CYCLES, 400_000_000, idle cycles allowed during a load session before abort

Ports:
clk  in  1  system clock
i_rst_n  in  1  reset; asynchronous, active-low
i_rx_empty  in  1  Rx FIFO empty (show-ahead FIFO, data valid when 0)
i_rx_data  in  NB_UART_DATA  Rx FIFO head byte
o_rx_rd  out  1  Rx FIFO pop
i_tx_full  in  1  Tx FIFO full
o_tx_wr  out  1  Tx FIFO push
o_tx_data  out  NB_UART_DATA  Tx FIFO write byte
o_tx_start  out  1  UART Tx start
o_ldr_start  out  1  loader start pulse
o_ldr_rx_done  out  1  byte-available strobe to loader
o_ldr_rst  out  1  loader synchronous reset pulse
i_ldr_rd  in  1  loader Rx pop request
i_ldr_wr  in  1  loader Tx push request
i_ldr_wdata  in  NB_UART_DATA  loader Tx byte
i_ldr_tx_start  in  1  loader Tx start
i_ldr_done  in  1  loader finished (EOT seen)
i_cpu_end  in  1  CPU reached end of program
o_cpu_halt  out  1  CPU halt (1 = halted)
o_cpu_step  out  1  single-step pulse

Behaviour:
- Reset (async, i_rst_n=0):
  - State = IDLE.
  - o_cpu_halt=1; all other outputs 0.
  - cmd_reg=0, reply_reg=0, timeout counter=0.
- Command bytes: 'L'=0x4C load, 'R'=0x52 run, 'S'=0x53 step, 'H'=0x48 halt, 'P'=0x50 ping. ACK=0x05, NAK=0x15.
- States: IDLE, DECODE, LOAD, RUN, REPLY.
- IDLE: when i_rx_empty=0, o_rx_rd=1 for exactly one cycle, i_rx_data latched into cmd_reg, next state DECODE.
- DECODE (one cycle):
  - 'L': o_ldr_start=1, counter cleared -> LOAD.
  - 'R': o_cpu_halt<=0 -> RUN.
  - 'S': o_cpu_step=1 for this cycle only, reply_reg=ACK -> REPLY. o_cpu_halt stays 1.
  - 'H': o_cpu_halt<=1, reply_reg=ACK -> REPLY.
  - 'P': reply_reg=ACK -> REPLY.
  - Any other byte: reply_reg=NAK -> REPLY.
- LOAD (pass-through): the dispatcher drives no Tx of its own here.
  - o_ldr_rx_done = ~i_rx_empty.
  - o_rx_rd = i_ldr_rd & ~i_rx_empty.
  - o_tx_wr/o_tx_data/o_tx_start = i_ldr_wr/i_ldr_wdata/i_ldr_tx_start.
  - Timeout counter clears on any cycle with o_rx_rd=1; otherwise increments.
  - i_ldr_done=1 -> IDLE (the loader has already sent the final ACK).
  - Counter reaches TIMEOUT_CYCLES-1 without i_ldr_done -> o_ldr_rst=1 for one cycle, reply_reg=NAK -> REPLY.
  - i_ldr_done and timeout in the same cycle: done wins, no NAK.
- RUN: o_cpu_halt=0.
  - i_rx_empty=0: pop one byte per cycle. 'H' -> halt. Any other byte is discarded with no reply.
  - i_cpu_end=1 -> halt.
  - Halt sequence: o_cpu_halt<=1, reply_reg=ACK -> REPLY.
  - 'H' popped in the same cycle as i_cpu_end: a single ACK only.
- REPLY:
  - i_tx_full=0: o_tx_wr=1, o_tx_start=1, o_tx_data=reply_reg for one cycle -> IDLE.
  - i_tx_full=1: hold in REPLY, no push, no Rx pops.
- o_ldr_start, o_ldr_rst, o_cpu_step, o_rx_rd (outside LOAD) and o_tx_wr (outside LOAD) are single-cycle pulses.
- Reset mid-LOAD or mid-RUN: returns to IDLE with the CPU halted. No reply is sent, and o_ldr_rst is not pulsed (the loader shares the system reset).
- o_cpu_halt is registered. All other outputs are combinational from state and inputs.

Test Plan:
- Ping: push 0x50 -> one o_rx_rd pulse; 2 cycles later o_tx_wr=1 with o_tx_data=0x05; state back to IDLE.
- Unknown command: push 0x7A -> o_tx_data=0x15; o_cpu_halt stays 1.
- Load: push 0x4C then a 132-byte frame plus EOT via the loader model -> o_ldr_start pulses once; every loader rd/wr is mirrored on the FIFO ports; i_ldr_done returns to IDLE with no extra Tx byte.
- Load timeout (TIMEOUT_CYCLES=16): push 0x4C, then 3 bytes, then silence -> o_ldr_rst pulses exactly 16 cycles after the last pop; followed by NAK 0x15.
- Run/halt:
  - Push 0x52 -> o_cpu_halt falls.
  - Push 0x41 -> byte popped, no reply.
  - Push 0x48 in the same cycle as i_cpu_end=1 -> o_cpu_halt=1 and exactly one ACK.
- Step with backpressure: i_tx_full=1, push 0x53 -> o_cpu_step pulses one cycle and no push occurs. Release i_tx_full -> one ACK 0x05. Assert i_rst_n=0 mid-REPLY in a repeat run -> all outputs at reset values immediately.
